wb_xbar_rr: RTL and testbench



---
 rtl/wb_xbar_rr_pkg.sv | 31 +++
 rtl/wb_xbar_rr_if.sv | 34 +++
 rtl/wb_xbar_rr_arbiter.sv | 26 ++
 rtl/wb_xbar_rr.sv | 177 +++++++++++++++++
 tb/tb_wb_xbar_rr.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/wb_xbar_rr_pkg.sv
// Shared types and helpers for the round-robin Wishbone crossbar.
package wb_xbar_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   localparam int unsigned max_slaves = 8;
   localparam int unsigned max_adr_w  = 64;

   // Owner/last pointer width; a single master still gets a 1-bit pointer.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One-hot slave hit vector; the lowest matching slave wins on overlap.
   function automatic logic [max_slaves-1:0] decode(
      input logic [max_adr_w-1:0]            adr,
      input logic [max_slaves*max_adr_w-1:0] base,
      input logic [max_slaves*max_adr_w-1:0] mask,
      input int unsigned                     n
   );
      logic [max_slaves-1:0] hit;
      hit = '0;
      for (int unsigned j = 0; j < max_slaves; j++) begin
         if (j < n && hit == '0 &&
             (adr & mask[j*max_adr_w +: max_adr_w]) == base[j*max_adr_w +: max_adr_w])
            hit[j] = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/wb_xbar_rr_if.sv
// Bundled master-side and slave-side Wishbone classic signals of the crossbar.
interface wb_xbar_rr_if #(
   parameter int unsigned m_count   = 2,
   parameter int unsigned s_count   = 2,
   parameter int unsigned adr_width = 32,
   parameter int unsigned dat_width = 32,
   parameter int unsigned sel_width = dat_width / 8
);
   logic [m_count-1:0]           m_cyc, m_stb, m_we;
   logic [m_count*adr_width-1:0] m_adr;
   logic [m_count*dat_width-1:0] m_datwr;
   logic [m_count*sel_width-1:0] m_sel;
   logic [m_count*dat_width-1:0] m_datrd;
   logic [m_count-1:0]           m_ack, m_err;

   logic [s_count-1:0]           s_cyc, s_stb, s_we;
   logic [s_count*adr_width-1:0] s_adr;
   logic [s_count*dat_width-1:0] s_datwr;
   logic [s_count*sel_width-1:0] s_sel;
   logic [s_count*dat_width-1:0] s_datrd;
   logic [s_count-1:0]           s_ack, s_err;

   // The crossbar itself: slave to the requesting masters, master to the slaves.
   modport slave (
      input  m_cyc, m_stb, m_we, m_adr, m_datwr, m_sel, s_datrd, s_ack, s_err,
      output m_datrd, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel
   );

   // The surrounding system: drives master requests and slave responses.
   modport master (
      output m_cyc, m_stb, m_we, m_adr, m_datwr, m_sel, s_datrd, s_ack, s_err,
      input  m_datrd, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel
   );
endinterface

// File: rtl/wb_xbar_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module wb_rr_arbiter #(
   parameter int unsigned n     = 2,
   parameter int unsigned ptr_w = 1
) (
   input  logic [n-1:0]     req,
   input  logic [ptr_w-1:0] last,
   output logic             gnt_valid,
   output logic [ptr_w-1:0] gnt_idx
);
   int idx;

   // Walk from farthest to nearest so the nearest requester is written last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = int'(n); k >= 1; k--) begin
         idx = (int'(last) + k) % int'(n);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = ptr_w'(idx);
         end
      end
   end
endmodule

// File: rtl/wb_xbar_rr.sv
// M x S Wishbone classic crossbar: base/mask decode, per-slave round-robin with
// cycle lock, response routing, unmapped-address error and response timeout.
module wb_xbar_rr
   import wb_xbar_pkg::*;
#(
   parameter int unsigned                   m_count   = 2,
   parameter int unsigned                   s_count   = 2,
   parameter int unsigned                   adr_width = 32,
   parameter int unsigned                   dat_width = 32,
   parameter int unsigned                   sel_width = dat_width / 8,
   parameter logic [s_count*adr_width-1:0] s_base    = '0,
   parameter logic [s_count*adr_width-1:0] s_mask    = '0,
   parameter int unsigned                   timeout   = 256
) (
   input logic          clock,
   input logic          reset,
   wb_xbar_rr_if.slave  bus
);
   localparam int unsigned ptr_w    = ptr_width(m_count);
   localparam int unsigned cnt_w    = (timeout > 1) ? $clog2(timeout) : 1;
   localparam int unsigned tmo_last = (timeout > 0) ? timeout - 1 : 0;

   arb_state_t         state_q [s_count];
   arb_state_t         state_d [s_count];
   logic [ptr_w-1:0]   owner_q [s_count];
   logic [ptr_w-1:0]   owner_d [s_count];
   logic [ptr_w-1:0]   last_q  [s_count];
   logic [ptr_w-1:0]   last_d  [s_count];
   logic [cnt_w-1:0]   cnt_q   [s_count];
   logic [cnt_w-1:0]   cnt_d   [s_count];
   logic [m_count-1:0] err_q;

   logic [max_slaves*max_adr_w-1:0] base_ext, mask_ext;
   logic [s_count-1:0]  hit     [m_count];
   logic [s_count-1:0]  own_vec [m_count];
   logic [m_count-1:0]  owns, bad;
   logic [s_count-1:0]  cyc_raw, stb_raw, tmo;
   logic [m_count-1:0]  req     [s_count];
   logic [s_count-1:0]  gnt_valid;
   logic [ptr_w-1:0]    gnt_idx [s_count];

   // Re-pack the decode table at the package's fixed stride.
   always_comb begin
      base_ext = '0;
      mask_ext = '0;
      for (int j = 0; j < int'(s_count); j++) begin
         base_ext[j*max_adr_w +: max_adr_w] = max_adr_w'(s_base[j*adr_width +: adr_width]);
         mask_ext[j*max_adr_w +: max_adr_w] = max_adr_w'(s_mask[j*adr_width +: adr_width]);
      end
   end

   for (genvar i = 0; i < int'(m_count); i++) begin : g_dec
      assign hit[i] = s_count'(decode(max_adr_w'(bus.m_adr[i*adr_width +: adr_width]),
                                      base_ext, mask_ext, s_count));
   end

   // Ownership from registered state; flag requests that no owned/mapped slave can take.
   always_comb begin
      owns = '0;
      bad  = '0;
      for (int i = 0; i < int'(m_count); i++) begin
         own_vec[i] = '0;
         for (int j = 0; j < int'(s_count); j++)
            if (state_q[j] == BUSY && owner_q[j] == ptr_w'(i)) own_vec[i][j] = 1'b1;
         owns[i] = |own_vec[i];
         bad[i]  = bus.m_cyc[i] & bus.m_stb[i] &
                   ((hit[i] == '0) | (owns[i] & ~|(hit[i] & own_vec[i])));
      end
   end

   // Slave-side pass-through from the owner, with timeout expiry forcing cyc/stb low.
   always_comb begin
      cyc_raw     = '0;
      stb_raw     = '0;
      tmo         = '0;
      bus.s_we    = '0;
      bus.s_adr   = '0;
      bus.s_datwr = '0;
      bus.s_sel   = '0;
      for (int j = 0; j < int'(s_count); j++) begin
         for (int i = 0; i < int'(m_count); i++) begin
            if (own_vec[i][j]) begin
               cyc_raw[j] = bus.m_cyc[i];
               stb_raw[j] = bus.m_stb[i] & hit[i][j];
               bus.s_we[j] = bus.m_we[i];
               bus.s_adr[j*adr_width +: adr_width]   = bus.m_adr[i*adr_width +: adr_width];
               bus.s_datwr[j*dat_width +: dat_width] = bus.m_datwr[i*dat_width +: dat_width];
               bus.s_sel[j*sel_width +: sel_width]   = bus.m_sel[i*sel_width +: sel_width];
            end
         end
         tmo[j] = (timeout != 0) && stb_raw[j] && !bus.s_ack[j] && !bus.s_err[j] &&
                  (cnt_q[j] == cnt_w'(tmo_last));
      end
      bus.s_cyc = cyc_raw & ~tmo;
      bus.s_stb = stb_raw & ~tmo;
   end

   // Master-side response routing.
   always_comb begin
      bus.m_ack   = '0;
      bus.m_err   = err_q;
      bus.m_datrd = '0;
      for (int i = 0; i < int'(m_count); i++) begin
         for (int j = 0; j < int'(s_count); j++) begin
            if (own_vec[i][j]) begin
               bus.m_ack[i] = bus.s_ack[j] & bus.s_stb[j];
               bus.m_err[i] = err_q[i] | (bus.s_err[j] & bus.s_stb[j]) | tmo[j];
               bus.m_datrd[i*dat_width +: dat_width] = bus.s_datrd[j*dat_width +: dat_width];
            end
         end
      end
   end

   always_comb begin
      for (int j = 0; j < int'(s_count); j++) begin
         req[j] = '0;
         for (int i = 0; i < int'(m_count); i++)
            req[j][i] = bus.m_cyc[i] & bus.m_stb[i] & hit[i][j] & ~owns[i];
      end
   end

   for (genvar j = 0; j < int'(s_count); j++) begin : g_arb
      wb_rr_arbiter #(.n(m_count), .ptr_w(ptr_w)) u_arb (
         .req       (req[j]),
         .last      (last_q[j]),
         .gnt_valid (gnt_valid[j]),
         .gnt_idx   (gnt_idx[j])
      );
   end

   // Per-slave arbiter next state and timeout counter.
   always_comb begin
      for (int j = 0; j < int'(s_count); j++) begin
         state_d[j] = state_q[j];
         owner_d[j] = owner_q[j];
         last_d[j]  = last_q[j];
         cnt_d[j]   = '0;
         unique case (state_q[j])
            IDLE: begin
               if (gnt_valid[j]) begin
                  state_d[j] = BUSY;
                  owner_d[j] = gnt_idx[j];
                  last_d[j]  = gnt_idx[j];
               end
            end
            BUSY: begin
               if (tmo[j] || !cyc_raw[j])               state_d[j] = IDLE;
               else if (bus.s_ack[j] || bus.s_err[j])  cnt_d[j]   = '0;
               else if (stb_raw[j])                    cnt_d[j]   = cnt_q[j] + cnt_w'(1);
               else                                    cnt_d[j]   = cnt_q[j];
            end
            default: state_d[j] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int j = 0; j < int'(s_count); j++) begin
            state_q[j] <= IDLE;
            owner_q[j] <= '0;
            last_q[j]  <= ptr_w'(m_count - 1);
            cnt_q[j]   <= '0;
         end
         err_q <= '0;
      end else begin
         for (int j = 0; j < int'(s_count); j++) begin
            state_q[j] <= state_d[j];
            owner_q[j] <= owner_d[j];
            last_q[j]  <= last_d[j];
            cnt_q[j]   <= cnt_d[j];
         end
         // Toggling keeps a held bad request from seeing a continuous err.
         err_q <= bad & ~err_q;
      end
   end
endmodule

// File: tb/tb_wb_xbar_rr.sv
// Directed bench for wb_xbar_rr: 2 masters, slave 0 at 0x0000, slave 1 at 0x1000.
module tb_wb_xbar_rr;
   logic clock;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   wb_xbar_rr_if #(.m_count(2), .s_count(2), .adr_width(32), .dat_width(32), .sel_width(4)) bus ();

   wb_xbar_rr #(
      .m_count(2), .s_count(2), .adr_width(32), .dat_width(32), .sel_width(4),
      .s_base({32'h0000_1000, 32'h0000_0000}),
      .s_mask({32'h0000_F000, 32'h0000_F000}),
      .timeout(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic mreq(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      bus.m_cyc[m] = cyc;
      bus.m_stb[m] = stb;
      bus.m_we[m]  = we;
      bus.m_adr[m*32 +: 32]   = adr;
      bus.m_datwr[m*32 +: 32] = dat;
      bus.m_sel[m*4 +: 4]     = sel;
   endtask

   initial begin
      reset = 1'b1;
      bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
      bus.m_adr = '0; bus.m_datwr = '0; bus.m_sel = '0;
      bus.s_ack = 2'b11;
      bus.s_err = 2'b00;
      bus.s_datrd = {32'hC3C3_1111, 32'h5A5A_0000};

      // Reset state
      repeat (2) nxt();
      smp();
      chk("rst_s_cyc", 64'(bus.s_cyc), 64'h0);
      chk("rst_s_stb", 64'(bus.s_stb), 64'h0);
      chk("rst_m_ack", 64'(bus.m_ack), 64'h0);
      chk("rst_m_err", 64'(bus.m_err), 64'h0);
      chk("rst_m_datrd", bus.m_datrd, 64'h0);
      chk("rst_s_adr", bus.s_adr, 64'h0);
      nxt(); reset = 1'b0; smp();

      // Write to slave 1
      nxt(); mreq(0, 1, 1, 1, 32'h1004, 32'hDEAD_BEEF, 4'hF); smp();
      chk("wr_no_early_stb", 64'(bus.s_stb), 64'h0);
      nxt(); smp();
      chk("wr_s_stb", 64'(bus.s_stb), 64'h2);
      chk("wr_s_cyc", 64'(bus.s_cyc), 64'h2);
      chk("wr_s_adr", 64'(bus.s_adr[63:32]), 64'h1004);
      chk("wr_s_dat", 64'(bus.s_datwr[63:32]), 64'hDEAD_BEEF);
      chk("wr_s_sel", 64'(bus.s_sel[7:4]), 64'hF);
      chk("wr_s_we", 64'(bus.s_we[1]), 64'h1);
      chk("wr_m_ack", 64'(bus.m_ack), 64'h1);
      nxt(); mreq(0, 0, 0, 0, 32'h0, 32'h0, 4'h0); smp();
      chk("wr_end_cyc", 64'(bus.s_cyc), 64'h0);
      chk("wr_end_ack", 64'(bus.m_ack), 64'h0);
      nxt(); smp();

      // Round-robin fairness on slave 0
      nxt(); mreq(0, 1, 1, 0, 32'h10, 32'h0, 4'hF); mreq(1, 1, 1, 0, 32'h10, 32'h0, 4'hF); smp();
      chk("rr_no_early_stb", 64'(bus.s_stb), 64'h0);
      for (int r = 0; r < 4; r++) begin
         nxt(); smp();
         chk("rr_grant_ack", 64'(bus.m_ack), 64'(1 << (r % 2)));
         chk("rr_s_cyc", 64'(bus.s_cyc), 64'h1);
         chk("rr_datrd_owner", 64'(bus.m_datrd[(r % 2)*32 +: 32]), 64'h5A5A_0000);
         chk("rr_datrd_other", 64'(bus.m_datrd[(1 - r % 2)*32 +: 32]), 64'h0);
         nxt(); mreq(r % 2, 0, 0, 0, 32'h10, 32'h0, 4'hF); smp();
         chk("rr_gap_cyc", 64'(bus.s_cyc), 64'h0);
         chk("rr_gap_ack", 64'(bus.m_ack), 64'h0);
         nxt();
         if (r < 3) mreq(r % 2, 1, 1, 0, 32'h10, 32'h0, 4'hF);
         else begin
            mreq(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
            mreq(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
         end
         smp();
         chk("rr_idle_cyc", 64'(bus.s_cyc), 64'h0);
      end

      // Cycle lock: M1 holds slave 0 across three beats plus an idle-stb cycle
      nxt(); mreq(1, 1, 1, 0, 32'h20, 32'h0, 4'hF); smp();
      nxt(); mreq(0, 1, 1, 0, 32'h10, 32'h0, 4'hF); smp();
      chk("lock_beat1_ack", 64'(bus.m_ack), 64'h2);
      chk("lock_beat1_adr", 64'(bus.s_adr[31:0]), 64'h20);
      nxt(); smp();
      chk("lock_beat2_ack", 64'(bus.m_ack), 64'h2);
      nxt(); smp();
      chk("lock_beat3_ack", 64'(bus.m_ack), 64'h2);
      chk("lock_no_err", 64'(bus.m_err), 64'h0);
      nxt(); mreq(1, 1, 0, 0, 32'h20, 32'h0, 4'hF); smp();
      chk("lock_hold_cyc", 64'(bus.s_cyc), 64'h1);
      chk("lock_hold_stb", 64'(bus.s_stb), 64'h0);
      chk("lock_hold_ack", 64'(bus.m_ack), 64'h0);
      nxt(); mreq(1, 0, 0, 0, 32'h0, 32'h0, 4'h0); smp();
      chk("lock_drop_cyc", 64'(bus.s_cyc), 64'h0);
      nxt(); smp();
      chk("lock_idle_stb", 64'(bus.s_stb), 64'h0);
      nxt(); smp();
      chk("lock_m0_stb", 64'(bus.s_stb), 64'h1);
      chk("lock_m0_ack", 64'(bus.m_ack), 64'h1);
      chk("lock_m0_adr", 64'(bus.s_adr[31:0]), 64'h10);
      nxt(); mreq(0, 0, 0, 0, 32'h0, 32'h0, 4'h0); smp();
      nxt(); smp();

      // Unmapped address
      nxt(); mreq(0, 1, 1, 0, 32'h2000, 32'h0, 4'hF); smp();
      chk("unm_err_early", 64'(bus.m_err), 64'h0);
      chk("unm_stb_early", 64'(bus.s_stb), 64'h0);
      nxt(); smp();
      chk("unm_err", 64'(bus.m_err), 64'h1);
      chk("unm_stb", 64'(bus.s_stb), 64'h0);
      chk("unm_cyc", 64'(bus.s_cyc), 64'h0);
      chk("unm_datrd", 64'(bus.m_datrd[31:0]), 64'h0);
      nxt(); mreq(0, 0, 0, 0, 32'h0, 32'h0, 4'h0); smp();
      chk("unm_err_end", 64'(bus.m_err), 64'h0);

      // Timeout with slave 0 silent
      nxt(); bus.s_ack = 2'b10; mreq(0, 1, 1, 0, 32'h10, 32'h0, 4'hF); smp();
      for (int t = 1; t <= 3; t++) begin
         nxt(); smp();
         chk("tmo_wait_cyc", 64'(bus.s_cyc), 64'h1);
         chk("tmo_wait_err", 64'(bus.m_err), 64'h0);
      end
      nxt(); smp();
      chk("tmo_err", 64'(bus.m_err), 64'h1);
      chk("tmo_cyc", 64'(bus.s_cyc), 64'h0);
      chk("tmo_stb", 64'(bus.s_stb), 64'h0);
      chk("tmo_ack", 64'(bus.m_ack), 64'h0);
      nxt(); mreq(0, 0, 0, 0, 32'h0, 32'h0, 4'h0); smp();
      chk("tmo_after_err", 64'(bus.m_err), 64'h0);

      // Ack arriving on the expiry cycle wins over the timeout
      nxt(); mreq(0, 1, 1, 0, 32'h10, 32'h0, 4'hF); smp();
      for (int t = 1; t <= 3; t++) begin
         nxt(); smp();
      end
      nxt(); bus.s_ack = 2'b11; smp();
      chk("tmoack_ack", 64'(bus.m_ack), 64'h1);
      chk("tmoack_err", 64'(bus.m_err), 64'h0);
      chk("tmoack_cyc", 64'(bus.s_cyc), 64'h1);
      nxt(); mreq(0, 0, 0, 0, 32'h0, 32'h0, 4'h0); smp();
      nxt(); smp();

      // Reset during a BUSY read, then contention after reset
      nxt(); bus.s_ack = 2'b10; mreq(0, 1, 1, 0, 32'h14, 32'h0, 4'hF); smp();
      nxt(); smp();
      chk("rstb_busy_stb", 64'(bus.s_stb), 64'h1);
      nxt(); reset = 1'b1; smp();
      nxt(); reset = 1'b0; mreq(1, 1, 1, 0, 32'h18, 32'h0, 4'hF); smp();
      chk("rstb_s_cyc", 64'(bus.s_cyc), 64'h0);
      chk("rstb_s_stb", 64'(bus.s_stb), 64'h0);
      chk("rstb_m_ack", 64'(bus.m_ack), 64'h0);
      chk("rstb_m_err", 64'(bus.m_err), 64'h0);
      nxt(); smp();
      chk("rstb_m0_wins", 64'(bus.s_stb), 64'h1);
      chk("rstb_m0_adr", 64'(bus.s_adr[31:0]), 64'h14);
      chk("rstb_no_err", 64'(bus.m_err), 64'h0);
      nxt(); mreq(0, 0, 0, 0, 32'h0, 32'h0, 4'h0); mreq(1, 0, 0, 0, 32'h0, 32'h0, 4'h0); smp();
      chk("rstb_end_cyc", 64'(bus.s_cyc), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
